// File: rtl/mem_map_pkg.sv
// Purpose : shared address map for the data-memory responder.
//           Holds the MMIO window tag, the register offsets inside the
//           window, the CONS_STAT bit layout and a helper that packs
//           the status word.
// Contents: MMIO_TAG_DEFAULT, OFF_* offsets, STAT_* bit positions,
//           sel_t decode enum, pack_stat() function.
package mem_map_pkg;

    localparam logic [15:0] MMIO_TAG_DEFAULT = 16'hFFFF;

    localparam logic [7:0] OFF_CONS_DATA = 8'h00;
    localparam logic [7:0] OFF_CONS_STAT = 8'h04;
    localparam logic [7:0] OFF_CYCLE     = 8'h08;
    localparam logic [7:0] OFF_LEDS      = 8'h0C;

    localparam int STAT_OVF_BIT   = 31;
    localparam int STAT_COUNT_LSB = 2;
    localparam int STAT_COUNT_W   = 6;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_EMPTY_BIT = 0;

    // Target selected by the current M-stage address.
    typedef enum logic [2:0] {
        SEL_NONE      = 3'd0,
        SEL_RAM       = 3'd1,
        SEL_CONS_DATA = 3'd2,
        SEL_CONS_STAT = 3'd3,
        SEL_CYCLE     = 3'd4,
        SEL_LEDS      = 3'd5
    } sel_t;

    // Build the CONS_STAT read word; unused bits read as zero.
    function automatic logic [31:0] pack_stat(
        input logic                    ovf,
        input logic [STAT_COUNT_W-1:0] count,
        input logic                    full,
        input logic                    empty
    );
        logic [31:0] word;
        word                                 = 32'h0000_0000;
        word[STAT_OVF_BIT]                   = ovf;
        word[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
        word[STAT_FULL_BIT]                  = full;
        word[STAT_EMPTY_BIT]                 = empty;
        return word;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose : single-clock FIFO used as the console TX queue.
// Ports   : clk, reset (sync, active-low), push/push_data, pop/pop_data,
//           full, empty, count (0..DEPTH), push_dropped (push refused).
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle. pop_data reads zero while empty so the head never shows stale data.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       push_dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign empty        = (count_r == CW'(0));
    assign full         = (count_r == CW'(DEPTH));
    assign count        = count_r;
    assign pop_ok_s     = pop && !empty;
    assign push_ok_s    = push && (!full || pop_ok_s);
    assign push_dropped = push && !push_ok_s;
    assign pop_data     = empty ? '0 : mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Purpose : data-memory responder for the pipelined core's M stage.
//           Word RAM everywhere except the MMIO window (addr[31:16] ==
//           MMIO_TAG), which holds console TX FIFO, cycle counter and LEDs.
// Ports   : clk, reset (sync, active-low), addr/we/wdata from the core,
//           rdata (combinational, same cycle), cons_valid/cons_data/
//           cons_ready drain side of the console FIFO, leds.
module dmem_mmio_responder
    import mem_map_pkg::*;
#(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] MMIO_TAG   = MMIO_TAG_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        cons_valid,
    output logic [7:0]  cons_data,
    input  logic        cons_ready,
    output logic [7:0]  leds
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram_r [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx_s;
    logic [7:0]        offset_s;
    sel_t              sel_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              fifo_drop_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [7:0]        fifo_head_s;
    logic              ovf_clr_s;
    logic              ovf_r;
    logic [31:0]       cycle_r;
    logic [7:0]        leds_r;
    logic              unused_addr_s;

    // Upper bits alias in RAM; word access ignores the byte lane bits.
    assign ram_idx_s     = addr[2 +: RAM_AW];
    assign offset_s      = {addr[7:2], 2'b00};
    assign unused_addr_s = ^{addr[15:8], addr[1:0]};

    // Address decode into one target per access.
    always_comb begin
        sel_s = SEL_NONE;
        if (addr[31:16] != MMIO_TAG) begin
            sel_s = SEL_RAM;
        end else begin
            case (offset_s)
                OFF_CONS_DATA: sel_s = SEL_CONS_DATA;
                OFF_CONS_STAT: sel_s = SEL_CONS_STAT;
                OFF_CYCLE:     sel_s = SEL_CYCLE;
                OFF_LEDS:      sel_s = SEL_LEDS;
                default:       sel_s = SEL_NONE;
            endcase
        end
    end

    assign fifo_push_s = we && (sel_s == SEL_CONS_DATA);
    assign fifo_pop_s  = !fifo_empty_s && cons_ready;
    assign ovf_clr_s   = we && (sel_s == SEL_CONS_STAT) && wdata[STAT_OVF_BIT];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_cons_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (fifo_push_s),
        .push_data    (wdata[7:0]),
        .pop          (fifo_pop_s),
        .pop_data     (fifo_head_s),
        .full         (fifo_full_s),
        .empty        (fifo_empty_s),
        .count        (fifo_count_s),
        .push_dropped (fifo_drop_s)
    );

    assign cons_valid = !fifo_empty_s;
    assign cons_data  = fifo_head_s;
    assign leds       = leds_r;

    // Same-cycle read mux; CONS_DATA and unmapped offsets read zero.
    always_comb begin
        rdata = 32'h0000_0000;
        case (sel_s)
            SEL_RAM:       rdata = ram_r[ram_idx_s];
            SEL_CONS_STAT: rdata = pack_stat(ovf_r, STAT_COUNT_W'(fifo_count_s),
                                             fifo_full_s, fifo_empty_s);
            SEL_CYCLE:     rdata = cycle_r;
            SEL_LEDS:      rdata = {24'h00_0000, leds_r};
            default:       rdata = 32'h0000_0000;
        endcase
    end

    // RAM write port; contents survive reset but writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (reset && we && (sel_s == SEL_RAM)) begin
            ram_r[ram_idx_s] <= wdata;
        end
    end

    // MMIO registers: sticky overflow, free-running cycle counter, LEDs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_r   <= 1'b0;
            cycle_r <= 32'h0000_0000;
            leds_r  <= 8'h00;
        end else begin
            if (fifo_drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
            if (we && (sel_s == SEL_CYCLE)) begin
                cycle_r <= wdata;
            end else begin
                cycle_r <= cycle_r + 32'd1;
            end
            if (we && (sel_s == SEL_LEDS)) begin
                leds_r <= wdata[7:0];
            end
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: a behavioural model (queue
// FIFO, associative-array RAM) tracks every cycle, a constant vector table
// covers RAM aliasing and LED/unmapped decode, hand sequences cover reset,
// FIFO overflow/drain, full push+pop and counter wrap, then random traffic.
module tb_dmem_mmio_responder;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        cons_valid;
    logic [7:0]  cons_data;
    logic        cons_ready;
    logic [7:0]  leds;

    dmem_mmio_responder dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .we         (we),
        .wdata      (wdata),
        .rdata      (rdata),
        .cons_valid (cons_valid),
        .cons_data  (cons_data),
        .cons_ready (cons_ready),
        .leds       (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state
    logic [31:0] m_ram [int];
    logic [7:0]  m_fifo [$];
    logic        m_ovf;
    logic [31:0] m_cyc;
    logic [7:0]  m_leds;
    logic        m_init = 1'b0;

    // Values observed during the most recent step
    logic [31:0] o_rdata;
    logic        o_valid;
    logic [7:0]  o_data;
    logic [7:0]  o_leds;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic logic m_read(input logic [31:0] a, output logic [31:0] v);
        logic [7:0] off;
        int n;
        n = m_fifo.size();
        v = 32'h0;
        if (a[31:16] != 16'hFFFF) begin
            if (m_ram.exists(int'((a >> 2) & 32'd63))) begin
                v = m_ram[int'((a >> 2) & 32'd63)];
                return 1'b1;
            end
            return 1'b0;
        end
        off = a[7:0] & 8'hFC;
        if (off == 8'h04)
            v = (m_ovf ? 32'h8000_0000 : 32'h0) | (32'(n) << 2)
              | ((n == 8) ? 32'h2 : 32'h0) | ((n == 0) ? 32'h1 : 32'h0);
        else if (off == 8'h08) v = m_cyc;
        else if (off == 8'h0C) v = {24'h0, m_leds};
        return 1'b1;
    endfunction

    // One clock cycle: drive, sample and compare with the model, then advance the model.
    task automatic step(input logic rst, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic rdy);
        logic [31:0] ev;
        logic known, mmio, full_before, pop;
        logic [7:0] off;
        @(negedge clk);
        reset = rst; addr = a; we = w; wdata = d; cons_ready = rdy;
        #1;
        o_rdata = rdata; o_valid = cons_valid; o_data = cons_data; o_leds = leds;
        if (m_init) begin
            known = m_read(a, ev);
            if (known) check("model_rdata", rdata, ev);
            check("model_cons_valid", {31'h0, cons_valid}, {31'h0, m_fifo.size() != 0});
            check("model_cons_data", {24'h0, cons_data},
                  {24'h0, (m_fifo.size() != 0) ? m_fifo[0] : 8'h00});
            check("model_leds", {24'h0, leds}, {24'h0, m_leds});
        end
        @(posedge clk);
        if (!rst) begin
            m_fifo.delete();
            m_ovf = 1'b0; m_cyc = 32'h0; m_leds = 8'h0; m_init = 1'b1;
        end else begin
            mmio = (a[31:16] == 16'hFFFF);
            off = a[7:0] & 8'hFC;
            full_before = (m_fifo.size() == 8);
            pop = (m_fifo.size() != 0) && rdy;
            if (pop) void'(m_fifo.pop_front());
            if (w && mmio && off == 8'h00) begin
                if (!full_before || pop) m_fifo.push_back(d[7:0]);
                else m_ovf = 1'b1;
            end
            if (w && mmio && off == 8'h04 && d[31]) m_ovf = 1'b0;
            if (w && mmio && off == 8'h08) m_cyc = d;
            else m_cyc = m_cyc + 32'd1;
            if (w && mmio && off == 8'h0C) m_leds = d[7:0];
            if (w && !mmio) m_ram[int'((a >> 2) & 32'd63)] = d;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic        chk;
        logic [31:0] exp_rd;
        logic [7:0]  exp_leds;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; addr = 32'h0; we = 1'b0; wdata = 32'h0; cons_ready = 1'b0;

        // Reset held two cycles with an LED write in flight
        step(1'b0, 32'hFFFF_000C, 1'b1, 32'h0000_00FF, 1'b0);
        step(1'b0, 32'hFFFF_000C, 1'b1, 32'h0000_00FF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'hFFFF_0008, 1'b0, 32'h0, 1'b0);
            check("reset_cycle_read", o_rdata, 32'(i));
        end
        check("reset_leds", {24'h0, o_leds}, 32'h0);
        check("reset_cons_valid", {31'h0, o_valid}, 32'h0);
        check("reset_cons_data", {24'h0, o_data}, 32'h0);

        // Vector table: RAM alias, LEDs, unmapped and CONS_DATA reads
        vecs[0] = '{32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         8'h00};
        vecs[1] = '{32'h0000_0010, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 8'h00};
        vecs[2] = '{32'h0000_0110, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 8'h00};
        vecs[3] = '{32'h0000_0113, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 8'h00};
        vecs[4] = '{32'hFFFF_000C, 1'b1, 32'h1234_5678, 1'b1, 32'h0,         8'h00};
        vecs[5] = '{32'hFFFF_000C, 1'b0, 32'h0,         1'b1, 32'h0000_0078, 8'h78};
        vecs[6] = '{32'hFFFF_0020, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0,         8'h78};
        vecs[7] = '{32'hFFFF_0020, 1'b0, 32'h0,         1'b1, 32'h0,         8'h78};
        vecs[8] = '{32'hFFFF_0000, 1'b0, 32'h0,         1'b1, 32'h0,         8'h78};
        vecs[9] = '{32'hFFFF_0004, 1'b0, 32'h0,         1'b1, 32'h0000_0001, 8'h78};
        for (int i = 0; i < 10; i++) begin
            step(1'b1, vecs[i].a, vecs[i].w, vecs[i].d, 1'b0);
            if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), o_rdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_leds", i), {24'h0, o_leds}, {24'h0, vecs[i].exp_leds});
        end

        // Overflow: nine pushes into an undrained FIFO, then drain
        for (int i = 0; i < 9; i++) step(1'b1, 32'hFFFF_0000, 1'b1, 32'(8'h41 + i), 1'b0);
        step(1'b1, 32'hFFFF_0004, 1'b0, 32'h0, 1'b0);
        check("ovf_stat", o_rdata, 32'h8000_0022);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'hFFFF_0020, 1'b0, 32'h0, 1'b1);
            check("drain_valid", {31'h0, o_valid}, 32'h1);
            check("drain_byte", {24'h0, o_data}, 32'(8'h41 + i));
        end
        step(1'b1, 32'hFFFF_0004, 1'b1, 32'h8000_0000, 1'b1);
        check("drained_empty", {31'h0, o_valid}, 32'h0);
        check("drained_stat", o_rdata, 32'h8000_0001);
        step(1'b1, 32'hFFFF_0004, 1'b0, 32'h0, 1'b0);
        check("ovf_cleared", o_rdata, 32'h0000_0001);

        // Full FIFO: push with a same-cycle pop is accepted
        for (int i = 0; i < 8; i++) step(1'b1, 32'hFFFF_0000, 1'b1, 32'(8'h30 + i), 1'b0);
        step(1'b1, 32'hFFFF_0000, 1'b1, 32'h0000_005A, 1'b1);
        check("full_pushpop_head", {24'h0, o_data}, 32'h30);
        step(1'b1, 32'hFFFF_0004, 1'b0, 32'h0, 1'b0);
        check("full_pushpop_stat", o_rdata, 32'h0000_0022);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'hFFFF_0020, 1'b0, 32'h0, 1'b1);
            check("full_drain_byte", {24'h0, o_data}, (i < 7) ? 32'(8'h31 + i) : 32'h5A);
        end

        // Cycle counter load and wrap
        step(1'b1, 32'hFFFF_0008, 1'b1, 32'hFFFF_FFFE, 1'b0);
        step(1'b1, 32'hFFFF_0008, 1'b0, 32'h0, 1'b0);
        check("cycle_wrap0", o_rdata, 32'hFFFF_FFFE);
        step(1'b1, 32'hFFFF_0008, 1'b0, 32'h0, 1'b0);
        check("cycle_wrap1", o_rdata, 32'hFFFF_FFFF);
        step(1'b1, 32'hFFFF_0008, 1'b0, 32'h0, 1'b0);
        check("cycle_wrap2", o_rdata, 32'h0000_0000);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a, d;
            logic w, r, rst;
            int k;
            rst = ($urandom_range(0, 63) != 0);
            k = $urandom_range(0, 7);
            if (k < 2) begin
                a = (($urandom_range(0, 1) != 0) ? 32'h1234_0000 : 32'h0)
                  | ($urandom & 32'h0000_03FC) | 32'($urandom_range(0, 3));
            end else begin
                logic [7:0] offs [6];
                offs = '{8'h00, 8'h00, 8'h04, 8'h08, 8'h0C, 8'h20};
                a = {16'hFFFF, 8'($urandom), offs[$urandom_range(0, 5)] | 8'($urandom_range(0, 3))};
            end
            w = rst && ($urandom_range(0, 1) != 0);
            d = $urandom;
            r = ($urandom_range(0, 9) < 3);
            step(rst, a, w, d, r);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
